// File: rtl/mdu_if.sv
// MDU request/response bundle: operands, opcode and start from the pipeline;
// busy, HI/LO and mfhi/mflo read data back to it.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO, Out
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO, Out
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: fixed-latency mult (5) and div (10)
// on operands latched at start, plus mthi/mtlo writes and mfhi/mflo reads.
module mdu (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    mdu_op_e     op_q,    op_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        op_signed;
    logic        start_op;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    assign start_op = bus.Start &&
                      (bus.MDUOp == OP_MULT || bus.MDUOp == OP_MULTU ||
                       bus.MDUOp == OP_DIV  || bus.MDUOp == OP_DIVU);

    // Arithmetic works on latched operands only, so A/B may change freely during RUN.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_ext     = op_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        b_ext     = op_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod      = a_ext * b_ext;

        // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg = op_signed && a_q[31];
        b_neg = op_signed && b_q[31];
        a_mag = a_neg ? 32'('0 - a_q) : a_q;
        b_mag = b_neg ? 32'('0 - b_q) : b_q;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end else begin
            q_mag = '0;
            r_mag = '0;
        end
        quo = (a_neg ^ b_neg) ? 32'('0 - q_mag) : q_mag;
        rem = a_neg ? 32'('0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start_op) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = mdu_op_e'(bus.MDUOp);
                    cnt_d   = (bus.MDUOp == OP_MULT || bus.MDUOp == OP_MULTU) ? 4'd5 : 4'd10;
                    state_d = RUN;
                end else if (bus.MDUOp == OP_MTHI) begin
                    hi_d = bus.A;
                end else if (bus.MDUOp == OP_MTLO) begin
                    lo_d = bus.A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT, OP_MULTU: begin
                            hi_d = prod[63:32];
                            lo_d = prod[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        case (bus.MDUOp)
            OP_MFHI: bus.Out = hi_q;
            OP_MFLO: bus.Out = lo_q;
            default: bus.Out = '0;
        endcase
    end

    assign bus.Busy = (state_q == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO/Out/Busy expectations per scenario.
module tb_mdu;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mdu_if bus();

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.MDUOp = op;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.MDUOp = 4'd7;
        bus.Start = 1'b0;
        step();
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", bus.Busy); end
        vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 00000000", bus.HI); end
        vectors++; if (bus.LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 00000000", bus.LO); end
        vectors++; if (bus.Out !== 32'h0) begin miscompares++; $display("FAIL reset_out got %h want 00000000", bus.Out); end
        reset     = 1'b1;
        bus.MDUOp = 4'd0;
    endtask

    task automatic test_mult();
        int n;
        bus.A     = 32'hFFFF_FFFE;
        bus.B     = 32'd3;
        bus.MDUOp = 4'd1;
        bus.Start = 1'b1;
        #1;
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL start_cycle_busy got %0b want 0", bus.Busy); end
        step();
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        wait_done(n);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL mult_busy_len got %0d want 5", n); end
        vectors++; if (bus.HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", bus.HI); end
        vectors++; if (bus.LO !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", bus.LO); end
        // back-to-back: launched in the first IDLE cycle
        launch(4'd2, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL multu_busy_len got %0d want 5", n); end
        vectors++; if (bus.HI !== 32'h0000_0002) begin miscompares++; $display("FAIL multu_hi got %h want 00000002", bus.HI); end
        vectors++; if (bus.LO !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL multu_lo got %h want fffffffa", bus.LO); end
    endtask

    task automatic test_div();
        int n;
        launch(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL div_busy_len got %0d want 10", n); end
        vectors++; if (bus.LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", bus.LO); end
        vectors++; if (bus.HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", bus.HI); end
        launch(4'd4, 32'd7, 32'd0);
        wait_done(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL divzero_busy_len got %0d want 10", n); end
        vectors++; if (bus.LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL divzero_lo got %h want fffffffd", bus.LO); end
        vectors++; if (bus.HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divzero_hi got %h want ffffffff", bus.HI); end
        launch(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        vectors++; if (bus.LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_negb_lo got %h want fffffffd", bus.LO); end
        vectors++; if (bus.HI !== 32'h0000_0001) begin miscompares++; $display("FAIL div_negb_hi got %h want 00000001", bus.HI); end
        launch(4'd4, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        vectors++; if (bus.LO !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL divu_lo got %h want 0fffffff", bus.LO); end
        vectors++; if (bus.HI !== 32'h0000_000F) begin miscompares++; $display("FAIL divu_hi got %h want 0000000f", bus.HI); end
    endtask

    task automatic test_overflow_and_out_busy();
        int n;
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        bus.MDUOp = 4'd8;
        #1;
        vectors++; if (bus.Out !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL mflo_busy got %h want 0fffffff", bus.Out); end
        bus.MDUOp = 4'd7;
        #1;
        vectors++; if (bus.Out !== 32'h0000_000F) begin miscompares++; $display("FAIL mfhi_busy got %h want 0000000f", bus.Out); end
        bus.MDUOp = 4'd0;
        wait_done(n);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL ovf_busy_len got %0d want 10", n); end
        vectors++; if (bus.LO !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_lo got %h want 80000000", bus.LO); end
        vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL ovf_hi got %h want 00000000", bus.HI); end
    endtask

    task automatic test_ignored_while_busy();
        int c;
        launch(4'd1, 32'h0001_0000, 32'h0001_0000);
        c = 0;
        while (bus.Busy === 1'b1 && c < 40) begin
            c++;
            case (c)
                2: begin bus.MDUOp = 4'd5; bus.A = 32'h1234; end
                3: begin bus.MDUOp = 4'd1; bus.Start = 1'b1; bus.A = 32'd3; bus.B = 32'd3; end
                4: begin bus.MDUOp = 4'd0; bus.Start = 1'b0; end
                default: ;
            endcase
            step();
        end
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        vectors++; if (c !== 5) begin miscompares++; $display("FAIL ignored_busy_len got %0d want 5", c); end
        vectors++; if (bus.HI !== 32'h0000_0001) begin miscompares++; $display("FAIL ignored_hi got %h want 00000001", bus.HI); end
        vectors++; if (bus.LO !== 32'h0) begin miscompares++; $display("FAIL ignored_lo got %h want 00000000", bus.LO); end
    endtask

    task automatic test_move_ops();
        bus.A     = 32'h55;
        bus.MDUOp = 4'd6;
        step();
        vectors++; if (bus.LO !== 32'h55) begin miscompares++; $display("FAIL mtlo got %h want 00000055", bus.LO); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy got %0b want 0", bus.Busy); end
        bus.MDUOp = 4'd8;
        #1;
        vectors++; if (bus.Out !== 32'h55) begin miscompares++; $display("FAIL mflo got %h want 00000055", bus.Out); end
        bus.MDUOp = 4'd7;
        #1;
        vectors++; if (bus.Out !== 32'h1) begin miscompares++; $display("FAIL mfhi got %h want 00000001", bus.Out); end
        bus.A     = 32'hABCD;
        bus.MDUOp = 4'd5;
        step();
        vectors++; if (bus.HI !== 32'hABCD) begin miscompares++; $display("FAIL mthi got %h want 0000abcd", bus.HI); end
        bus.MDUOp = 4'd3;
        #1;
        vectors++; if (bus.Out !== 32'h0) begin miscompares++; $display("FAIL out_other_op got %h want 00000000", bus.Out); end
        bus.MDUOp = 4'd0;
    endtask

    task automatic test_start_qualify();
        bus.Start = 1'b1;
        bus.MDUOp = 4'd0;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL start_op0 got %0b want 0", bus.Busy); end
        bus.MDUOp = 4'd9;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL start_op9 got %0b want 0", bus.Busy); end
        bus.MDUOp = 4'd15;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL start_op15 got %0b want 0", bus.Busy); end
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
    endtask

    task automatic test_reset_mid_op();
        int n;
        launch(4'd3, 32'd100, 32'd7);
        step();
        step();
        step();
        vectors++; if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy_before got %0b want 1", bus.Busy); end
        reset = 1'b0;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL midop_busy got %0b want 0", bus.Busy); end
        vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL midop_hi got %h want 00000000", bus.HI); end
        vectors++; if (bus.LO !== 32'h0) begin miscompares++; $display("FAIL midop_lo got %h want 00000000", bus.LO); end
        reset = 1'b1;
        launch(4'd1, 32'd6, 32'd7);
        wait_done(n);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL post_reset_busy_len got %0d want 5", n); end
        vectors++; if (bus.LO !== 32'd42) begin miscompares++; $display("FAIL post_reset_lo got %h want 0000002a", bus.LO); end
        vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL post_reset_hi got %h want 00000000", bus.HI); end
    endtask

    task automatic test_reset_priority();
        reset     = 1'b0;
        bus.A     = 32'hDEAD;
        bus.MDUOp = 4'd5;
        step();
        vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL rst_prio_mthi got %h want 00000000", bus.HI); end
        bus.MDUOp = 4'd6;
        step();
        vectors++; if (bus.LO !== 32'h0) begin miscompares++; $display("FAIL rst_prio_mtlo got %h want 00000000", bus.LO); end
        bus.MDUOp = 4'd1;
        bus.Start = 1'b1;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rst_prio_start got %0b want 0", bus.Busy); end
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        reset     = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_mult();
        test_div();
        test_overflow_and_out_busy();
        test_ignored_while_busy();
        test_move_ops();
        test_start_qualify();
        test_reset_mid_op();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low; 0 at a rising clk edge resets the block.
REQ-003 The block SHALL have port A, input, 32 bits: operand 1 (rs), the same source as the EX-stage ALU operand A.
REQ-004 The block SHALL have port B, input, 32 bits: operand 2 (rt), the same source as the EX-stage ALU operand B.
REQ-005 The block SHALL have port MDUOp, input, 4 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 act as none.
REQ-006 The block SHALL have port Start, input, 1 bit: qualifies ops 1-4 in the current cycle.
REQ-007 The block SHALL have port Busy, output, 1 bit: an operation is in progress; reset value 0.
REQ-008 The block SHALL have port HI, output, 32 bits: HI register; reset value 0.
REQ-009 The block SHALL have port LO, output, 32 bits: LO register; reset value 0.
REQ-010 The block SHALL have port Out, output, 32 bits: read data for mfhi/mflo, muxed downstream with the ALU Result.

Function
REQ-011 The block SHALL use a two-state FSM: IDLE and RUN, with IDLE at reset.
REQ-012 In IDLE, Start=1 together with MDUOp 1-4 SHALL register A, B and the op, load the counter, and enter RUN on the next edge.
REQ-013 The counter SHALL be loaded with 5 for mult/multu and 10 for div/divu.
REQ-014 In RUN, the counter SHALL decrement once per cycle.
REQ-015 At counter value 1, the FSM SHALL write HI/LO and return to IDLE.
REQ-016 Busy SHALL be 1 exactly while in RUN: for a start at edge T, Busy is 1 for cycles T+1..T+N (N=5 or 10) and new HI/LO are visible from T+N+1.
REQ-017 Busy SHALL NOT be asserted combinationally in the Start cycle; the stall logic ORs Start with Busy.
REQ-018 mult SHALL produce the signed 64-bit product; multu SHALL produce the unsigned 64-bit product; {HI,LO} = product.
REQ-019 div SHALL compute the signed quotient truncated toward zero into LO and the remainder into HI, with the remainder taking the dividend's sign.
REQ-020 divu SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-021 For signed div of 0x80000000 by 0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0.
REQ-022 Division by zero (latched B=0) SHALL still run the full 10 cycles and SHALL leave HI and LO unchanged.
REQ-023 Results SHALL use the operands latched at start; changes on A/B during RUN SHALL have no effect.
REQ-024 Start with ops 1-4 while in RUN SHALL be ignored: no restart and no counter reload.
REQ-025 mthi SHALL write A to HI, and mtlo SHALL write A to LO, at the next edge, only when in IDLE.
REQ-026 mthi/mtlo while in RUN SHALL be ignored.
REQ-027 mthi/mtlo SHALL NOT require Start.
REQ-028 Start=1 with MDUOp 0 or 5-15 SHALL NOT start an operation.
REQ-029 Out SHALL be combinational: HI when MDUOp=7, LO when MDUOp=8, else 0.
REQ-030 Out SHALL reflect the current registered HI/LO, including while Busy.
REQ-031 Back-to-back operation: a start is accepted in the first IDLE cycle after RUN ends, with no dead cycle required.

Reset
REQ-032 reset=0 at any edge SHALL force IDLE, Busy=0, counter=0, HI=0 and LO=0, aborting any operation in progress with no HI/LO write.
REQ-033 reset=0 SHALL take priority over Start, mthi and mtlo in the same cycle.
REQ-034 After reset is released, the first edge SHALL accept a new op normally.

Verification
REQ-035 Signed multiply: mult with A=0xFFFFFFFE (-2), B=3, Start=1 -> Busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF and LO=0xFFFFFFFA. Unsigned multiply: multu with the same operands -> HI=0x00000002 and LO=0xFFFFFFFA.
REQ-036 Signed divide: div with A=0xFFFFFFF9 (-7), B=2 -> Busy=1 for exactly 10 cycles; afterwards LO=0xFFFFFFFD and HI=0xFFFFFFFF. Divide by zero: divu with A=7, B=0 -> HI/LO keep their prior values after 10 cycles.
REQ-037 Overflow divide: div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 Ignored ops while Busy: mthi with A=0x1234 in RUN cycle 2, and a Start of mult in RUN cycle 3, are ignored -> original result, Busy length unchanged. Writes and reads in IDLE: mtlo with A=0x55 -> LO=0x55 next cycle, and mflo -> Out=0x55.
REQ-039 Reset mid-operation: reset=0 in RUN cycle 4 of a div -> next cycle Busy=0 and HI=LO=0. After release, a mult of 6 by 7 -> LO=42 after 5 Busy cycles.
